// File: rtl/rr_pipe_arbiter.sv
// rtl/rr_pipe_arbiter.sv - round-robin arbiter serialising granted frames into a shared register chain
module rr_pipe_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8,
    parameter int DEPTH     = 2
) (
    input  logic                     _clock,
    input  logic                     _reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         din,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     dout,
    output logic                     dout_valid,
    output logic [$clog2(N_REQ)-1:0] dout_owner,
    output logic                     frame_done
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam int DRN_W = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_owner;
    logic [CNT_W-1:0]   bitcnt;
    logic [DRN_W-1:0]   drain_cnt;

    logic [DEPTH-1:0]   s_data;
    logic [DEPTH-1:0]   s_valid;
    logic [DEPTH-1:0]   s_last;
    logic [IDX_W-1:0]   s_tag [DEPTH];

    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               in_data;
    logic               in_valid;
    logic               in_last;
    logic [IDX_W-1:0]   in_tag;
    logic               last_bit;

    // Scan starts just past the previous owner so every requester gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last_owner) + i) % N_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign last_bit = (bitcnt == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        in_valid = (state == XFER);
        in_data  = in_valid ? din[owner] : 1'b0;
        in_last  = in_valid && last_bit;
        in_tag   = in_valid ? owner : '0;
    end

    always_ff @(negedge _clock or negedge _reset) begin
        if (!_reset) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
            bitcnt     <= '0;
            drain_cnt  <= '0;
            s_data     <= '0;
            s_valid    <= '0;
            s_last     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                s_tag[i] <= '0;
            end
        end else begin
            s_data  <= {s_data[DEPTH-2:0], in_data};
            s_valid <= {s_valid[DEPTH-2:0], in_valid};
            s_last  <= {s_last[DEPTH-2:0], in_last};
            s_tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                s_tag[i] <= s_tag[i-1];
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= winner;
                        grant  <= N_REQ'(1) << winner;
                        bitcnt <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    bitcnt <= bitcnt + CNT_W'(1);
                    if (last_bit) begin
                        grant      <= '0;
                        last_owner <= owner;
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Bubbles flush the chain so the final bit reaches dout before re-arbitration.
                    if (drain_cnt == DRN_W'(DEPTH - 2)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign dout       = s_data[DEPTH-1];
    assign dout_valid = s_valid[DEPTH-1];
    assign dout_owner = s_valid[DEPTH-1] ? s_tag[DEPTH-1] : '0;
    assign frame_done = s_valid[DEPTH-1] & s_last[DEPTH-1];

endmodule

// File: doc/rr_pipe_arbiter.md
RR_PIPE_ARBITER -- requirements
Module: rr_pipe_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter FRAME_LEN, default 8: bits per granted frame, at least 2.
REQ-003 SHALL have parameter DEPTH, default 2: shared register-chain stages, at least 2.
REQ-004 SHALL have port _clock, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-005 SHALL have port _reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, N_REQ bits: per-requester access request.
REQ-007 SHALL have port din, input, N_REQ bits: per-requester serial data bit.
REQ-008 SHALL have port grant, output, N_REQ bits: one-hot grant, registered.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 SHALL have port dout, output, 1 bit: shared chain output, the last stage.
REQ-011 SHALL have port dout_valid, output, 1 bit: dout carries a frame bit.
REQ-012 SHALL have port dout_owner, output, clog2(N_REQ) bits: requester index of the bit on dout.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse while the last frame bit is on dout.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, XFER, DRAIN.
REQ-015 SHALL, in IDLE at an edge with req nonzero, select a winner round-robin, scanning from (last_owner+1) mod N_REQ upward with wrap.
  - Same edge: set grant to one-hot(winner), clear bitcnt, enter XFER.
REQ-016 SHALL, in IDLE with req zero, hold state; grant stays 0.
REQ-017 SHALL, at each XFER edge, shift din[owner] into stage 0 with valid=1 and tag=owner, then increment bitcnt.
  - The requester presents frame bit k on the k-th edge with its grant high.
REQ-018 SHALL, at the XFER edge where bitcnt==FRAME_LEN-1, clear grant, set last_owner=owner, and enter DRAIN.
REQ-019 SHALL ignore req changes during XFER/DRAIN; a frame always completes FRAME_LEN bits even if req drops.
REQ-020 SHALL, in DRAIN, shift 0 with valid=0 into stage 0 for exactly DEPTH-1 edges, then enter IDLE.
  - No arbitration occurs on the DRAIN-to-IDLE edge, so one IDLE cycle minimum separates frames.
REQ-021 SHALL advance all DEPTH stages (data, valid, tag) every edge in all states; dout/dout_valid/dout_owner are the last stage.
REQ-022 SHALL show a bit on dout exactly DEPTH-1 edges after the edge that sampled it.
REQ-023 SHALL force dout_owner to 0 whenever dout_valid is 0.
REQ-024 SHALL assert frame_done combinationally from the last stage when it holds a frame's final bit.
  - Implemented via a per-stage last-bit flag.
REQ-025 SHALL never assert more than one grant bit, and never assert grant outside XFER.
REQ-026 SHALL re-grant the same requester when it is the only one requesting after its frame, with the pointer wrapping.

Reset
REQ-027 SHALL, while _reset=0 and independent of _clock, force:
  - state=IDLE, grant=0, busy=0, all stages (data/valid/tag/last)=0, bitcnt=0;
  - last_owner=N_REQ-1, so requester 0 has highest priority after reset.
REQ-028 SHALL abort any in-progress frame on reset assertion; partial bits are discarded, not resumed.
REQ-029 SHALL act on the first falling edge after _reset returns to 1.

Verification (N_REQ=4, FRAME_LEN=8, DEPTH=2)
REQ-030 Single requester: req=0100, din[2] serial 1,0,1,1,0,0,1,1
  -> grant=0100 for 8 edges;
  -> dout_valid high 8 cycles starting 1 edge after the first sample, dout=10110011, dout_owner=2;
  -> frame_done on the 8th valid bit; busy drops 1 edge later.
REQ-031 Full contention: req=1111 held
  -> grant order 0001,0010,0100,1000,0001;
  -> each grant 8 cycles, separated by 1 DRAIN cycle + 1 IDLE cycle.
REQ-032 Early drop: req[1] deasserted after 3 bits
  -> grant 0010 stays 8 edges, 8 valid bits emitted, frame_done once.
REQ-033 Reset mid-frame: _reset low at bit 4 of requester 3's frame
  -> grant, dout_valid, busy go 0 immediately without a clock edge;
  -> after release with req=1001, first grant=0001.
REQ-034 Idle and repeat:
  -> req=0000 for 20 cycles keeps all outputs 0;
  -> then req=0010 held gives consecutive frames all granted to requester 1, each separated by 2 non-granted cycles.
